// File: rtl/logic_axi4_stream_packet_buffer_counter.sv
// rtl/logic_axi4_stream_packet_buffer_counter.sv - FIFO occupancy counter (transfers and packets) from stream monitors
//
// Tracks how many single transfers and how many complete packets sit in a FIFO
// by watching the handshakes on its write side (rx_mon_*) and read side (tx_mon_*).
//
// Ports:
//   aclk, areset_n           clock, asynchronous active-low reset
//   rx_mon_tvalid/tready/tlast   observed FIFO write-side handshake (input only)
//   tx_mon_tvalid/tready/tlast   observed FIFO read-side handshake (input only)
//   packets_tdata/tvalid/tready  packet count stream, level semantics
//   transfers_tdata/tvalid/tready  transfer count stream, level semantics
//   overflow                 sticky: a count tried to go past MAX
//   underflow                sticky: a count tried to go below zero
module logic_axi4_stream_packet_buffer_counter #(
  parameter int CAPACITY       = 256,
  parameter int CAPACITY_WIDTH = (CAPACITY >= 2) ? $clog2(CAPACITY) : 1
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    rx_mon_tvalid,
  input  logic                    rx_mon_tready,
  input  logic                    rx_mon_tlast,
  input  logic                    tx_mon_tvalid,
  input  logic                    tx_mon_tready,
  input  logic                    tx_mon_tlast,
  output logic [CAPACITY_WIDTH:0] packets_tdata,
  output logic                    packets_tvalid,
  input  logic                    packets_tready,
  output logic [CAPACITY_WIDTH:0] transfers_tdata,
  output logic                    transfers_tvalid,
  input  logic                    transfers_tready,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int W = CAPACITY_WIDTH + 1;
  localparam logic [W-1:0] MAX = {1'b1, {CAPACITY_WIDTH{1'b0}}};

  logic         rx_hs, tx_hs;
  logic         xfer_inc, xfer_dec, pkt_inc, pkt_dec;
  logic [W-1:0] xfer_cnt, xfer_next, pkt_cnt, pkt_next;
  logic         xfer_ovf, xfer_unf, pkt_ovf, pkt_unf;

  assign rx_hs = rx_mon_tvalid && rx_mon_tready;
  assign tx_hs = tx_mon_tvalid && tx_mon_tready;

  // Simultaneous events on both sides cancel, so only a net step moves a count.
  assign xfer_inc = rx_hs && !tx_hs;
  assign xfer_dec = tx_hs && !rx_hs;
  assign pkt_inc  = (rx_hs && rx_mon_tlast) && !(tx_hs && tx_mon_tlast);
  assign pkt_dec  = (tx_hs && tx_mon_tlast) && !(rx_hs && rx_mon_tlast);

  always_comb begin
    xfer_next = xfer_cnt;
    xfer_ovf  = 1'b0;
    xfer_unf  = 1'b0;
    if (xfer_inc) begin
      if (xfer_cnt == MAX) xfer_ovf = 1'b1;
      else                 xfer_next = xfer_cnt + W'(1);
    end else if (xfer_dec) begin
      if (xfer_cnt == '0)  xfer_unf = 1'b1;
      else                 xfer_next = xfer_cnt - W'(1);
    end
  end

  always_comb begin
    pkt_next = pkt_cnt;
    pkt_ovf  = 1'b0;
    pkt_unf  = 1'b0;
    if (pkt_inc) begin
      if (pkt_cnt == MAX) pkt_ovf = 1'b1;
      else                pkt_next = pkt_cnt + W'(1);
    end else if (pkt_dec) begin
      if (pkt_cnt == '0)  pkt_unf = 1'b1;
      else                pkt_next = pkt_cnt - W'(1);
    end
  end

  // tvalid rises after a real count change (a saturated hold is not a change)
  // and drops once the consumer has seen the level with no newer change.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      xfer_cnt         <= '0;
      pkt_cnt          <= '0;
      transfers_tvalid <= 1'b0;
      packets_tvalid   <= 1'b0;
      overflow         <= 1'b0;
      underflow        <= 1'b0;
    end else begin
      xfer_cnt         <= xfer_next;
      pkt_cnt          <= pkt_next;
      transfers_tvalid <= (xfer_next != xfer_cnt) || (transfers_tvalid && !transfers_tready);
      packets_tvalid   <= (pkt_next != pkt_cnt) || (packets_tvalid && !packets_tready);
      overflow         <= overflow || xfer_ovf || pkt_ovf;
      underflow        <= underflow || xfer_unf || pkt_unf;
    end
  end

  assign transfers_tdata = xfer_cnt;
  assign packets_tdata   = pkt_cnt;

endmodule

// File: tb/tb_logic_axi4_stream_packet_buffer_counter.sv
// tb/tb_logic_axi4_stream_packet_buffer_counter.sv - directed bench for the packet buffer counter
module tb_logic_axi4_stream_packet_buffer_counter;

  logic       aclk = 1'b0;
  logic       areset_n;
  logic       rx_mon_tvalid, rx_mon_tready, rx_mon_tlast;
  logic       tx_mon_tvalid, tx_mon_tready, tx_mon_tlast;
  logic [2:0] packets_tdata, transfers_tdata;
  logic       packets_tvalid, transfers_tvalid;
  logic       packets_tready, transfers_tready;
  logic       overflow, underflow;

  int tests_run = 0;
  int tests_failed = 0;

  logic_axi4_stream_packet_buffer_counter #(.CAPACITY(4), .CAPACITY_WIDTH(2)) dut (
    .aclk             (aclk),
    .areset_n         (areset_n),
    .rx_mon_tvalid    (rx_mon_tvalid),
    .rx_mon_tready    (rx_mon_tready),
    .rx_mon_tlast     (rx_mon_tlast),
    .tx_mon_tvalid    (tx_mon_tvalid),
    .tx_mon_tready    (tx_mon_tready),
    .tx_mon_tlast     (tx_mon_tlast),
    .packets_tdata    (packets_tdata),
    .packets_tvalid   (packets_tvalid),
    .packets_tready   (packets_tready),
    .transfers_tdata  (transfers_tdata),
    .transfers_tvalid (transfers_tvalid),
    .transfers_tready (transfers_tready),
    .overflow         (overflow),
    .underflow        (underflow)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of monitor activity, then sample 1 time unit after the edge.
  task automatic cycle(input logic rx, input logic rx_last, input logic tx, input logic tx_last);
    rx_mon_tvalid = rx;
    rx_mon_tlast  = rx_last;
    tx_mon_tvalid = tx;
    tx_mon_tlast  = tx_last;
    @(posedge aclk);
    #1;
    rx_mon_tvalid = 1'b0;
    rx_mon_tlast  = 1'b0;
    tx_mon_tvalid = 1'b0;
    tx_mon_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    #2 areset_n = 1'b0;
    @(posedge aclk);
    #2 areset_n = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    areset_n = 1'b0;
    rx_mon_tvalid = 1'b0; rx_mon_tready = 1'b1; rx_mon_tlast = 1'b0;
    tx_mon_tvalid = 1'b0; tx_mon_tready = 1'b1; tx_mon_tlast = 1'b0;
    packets_tready = 1'b1; transfers_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_xfer", 32'(transfers_tdata), 0);
    check("rst_pkt", 32'(packets_tdata), 0);
    check("rst_xvalid", 32'(transfers_tvalid), 0);
    check("rst_pvalid", 32'(packets_tvalid), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);
    #2 areset_n = 1'b1;
    @(posedge aclk);
    #1;

    // Three writes, last one closes a packet.
    cycle(1, 0, 0, 0);
    check("w1_xfer", 32'(transfers_tdata), 1);
    check("w1_pkt", 32'(packets_tdata), 0);
    check("w1_xvalid", 32'(transfers_tvalid), 1);
    check("w1_pvalid", 32'(packets_tvalid), 0);
    cycle(1, 0, 0, 0);
    check("w2_xfer", 32'(transfers_tdata), 2);
    check("w2_pkt", 32'(packets_tdata), 0);
    check("w2_xvalid", 32'(transfers_tvalid), 1);
    cycle(1, 1, 0, 0);
    check("w3_xfer", 32'(transfers_tdata), 3);
    check("w3_pkt", 32'(packets_tdata), 1);
    check("w3_pvalid", 32'(packets_tvalid), 1);
    cycle(0, 0, 0, 0);
    check("idle_xvalid", 32'(transfers_tvalid), 0);
    check("idle_pvalid", 32'(packets_tvalid), 0);

    // Read one non-last beat: transfers=2, packets=1.
    cycle(0, 0, 1, 0);
    check("r1_xfer", 32'(transfers_tdata), 2);
    check("r1_pkt", 32'(packets_tdata), 1);
    cycle(0, 0, 0, 0);
    // Simultaneous last on both sides cancels out.
    cycle(1, 1, 1, 1);
    check("sim_xfer", 32'(transfers_tdata), 2);
    check("sim_pkt", 32'(packets_tdata), 1);
    check("sim_xvalid", 32'(transfers_tvalid), 0);
    check("sim_pvalid", 32'(packets_tvalid), 0);

    // Drain to empty, then underflow.
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 0);
    check("drain_xfer", 32'(transfers_tdata), 0);
    check("drain_pkt", 32'(packets_tdata), 0);
    check("drain_unf", 32'(underflow), 0);
    cycle(0, 0, 1, 1);
    check("unf_xfer", 32'(transfers_tdata), 0);
    check("unf_pkt", 32'(packets_tdata), 0);
    check("unf_flag", 32'(underflow), 1);
    check("unf_ovf", 32'(overflow), 0);
    do_reset();
    check("unf_cleared", 32'(underflow), 0);

    // Overflow on the 5th write, sticky after draining.
    for (int i = 1; i <= 4; i++) begin
      cycle(1, 0, 0, 0);
      check($sformatf("fill%0d_xfer", i), 32'(transfers_tdata), 32'(i));
      check($sformatf("fill%0d_ovf", i), 32'(overflow), 0);
    end
    cycle(1, 0, 0, 0);
    check("ovf_xfer", 32'(transfers_tdata), 4);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_pkt", 32'(packets_tdata), 0);
    repeat (4) cycle(0, 0, 1, 0);
    check("ovf_drain_xfer", 32'(transfers_tdata), 0);
    check("ovf_sticky", 32'(overflow), 1);
    check("ovf_no_unf", 32'(underflow), 0);
    do_reset();
    check("ovf_cleared", 32'(overflow), 0);

    // Consumer stalled: valid holds, data tracks the latest count.
    packets_tready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cycle(1, 1, 0, 0);
      check($sformatf("stall%0d_pkt", i), 32'(packets_tdata), 32'(i));
      check($sformatf("stall%0d_pvalid", i), 32'(packets_tvalid), 1);
    end
    cycle(0, 0, 0, 0);
    check("stall_hold_pvalid", 32'(packets_tvalid), 1);
    packets_tready = 1'b1;
    cycle(0, 0, 0, 0);
    check("stall_release_pvalid", 32'(packets_tvalid), 0);

    // Reach transfers=3 with overflow set, then async reset mid-cycle.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    check("pre_rst_xfer", 32'(transfers_tdata), 3);
    check("pre_rst_ovf", 32'(overflow), 1);
    rx_mon_tvalid = 1'b1;
    #2 areset_n = 1'b0;
    #1;
    check("arst_xfer", 32'(transfers_tdata), 0);
    check("arst_pkt", 32'(packets_tdata), 0);
    check("arst_ovf", 32'(overflow), 0);
    check("arst_xvalid", 32'(transfers_tvalid), 0);
    check("arst_pvalid", 32'(packets_tvalid), 0);
    @(posedge aclk);
    #1;
    check("arst_ignore_hs", 32'(transfers_tdata), 0);
    rx_mon_tvalid = 1'b0;
    #2 areset_n = 1'b1;
    @(posedge aclk);
    #1;
    cycle(1, 0, 0, 0);
    check("post_rst_xfer", 32'(transfers_tdata), 1);
    check("post_rst_xvalid", 32'(transfers_tvalid), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
